// File: rtl/room_light_controller_pkg.sv
// Shared lighting constants: sensor width, default thresholds, hold time
// and the per-room state encoding.
package room_light_controller_pkg;

  localparam int DAYLIGHT_SENSOR_DATA_WIDTH = 8;
  localparam int LIGHT_THRESHOLD            = 100;
  localparam int LIGHT_HYSTERESIS           = 20;
  localparam int DEFAULT_HOLD_CYCLES        = 1000;

  typedef enum logic [1:0] {
    ROOM_OFF  = 2'd0,
    ROOM_ON   = 2'd1,
    ROOM_HOLD = 2'd2
  } room_state_e;

  function automatic int hold_cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/room_light_controller_fsm.sv
// Per-room OFF/ON/HOLD controller with hold-off timer and manual override.
// The FSM keeps tracking occupancy while the override drives the light.
module room_light_fsm
  import room_light_controller_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic dark_i,
  input  logic presence_i,
  input  logic override_en_i,
  input  logic override_val_i,
  output logic light_o
);

  localparam int CNT_W = hold_cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  room_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             light_q;

  // Next-state and hold-timer decode; loss of darkness always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ROOM_OFF: begin
        if (presence_i && dark_i) state_d = ROOM_ON;
        else                      state_d = ROOM_OFF;
      end
      ROOM_ON: begin
        if (!dark_i) begin
          state_d = ROOM_OFF;
        end else if (!presence_i) begin
          state_d = ROOM_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = ROOM_ON;
        end
      end
      ROOM_HOLD: begin
        if (!dark_i) begin
          state_d = ROOM_OFF;
          cnt_d   = '0;
        end else if (presence_i) begin
          state_d = ROOM_ON;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ROOM_OFF;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ROOM_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // State, timer and light register; light reflects the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ROOM_OFF;
      cnt_q   <= '0;
      light_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      light_q <= override_en_i ? override_val_i : (state_d != ROOM_OFF);
    end
  end

  assign light_o = light_q;

endmodule

// File: rtl/room_light_controller.sv
// Multi-room lighting controller: one shared daylight hysteresis flag
// feeding an independent occupancy FSM per room.
module room_light_controller
  import room_light_controller_pkg::*;
#(
  parameter int NUM_ROOMS   = 4,
  parameter int DL_W        = DAYLIGHT_SENSOR_DATA_WIDTH,
  parameter int ON_THRESH   = LIGHT_THRESHOLD,
  parameter int OFF_THRESH  = LIGHT_THRESHOLD + LIGHT_HYSTERESIS,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DL_W-1:0]      daylight,
  input  logic [NUM_ROOMS-1:0] presence,
  input  logic [NUM_ROOMS-1:0] override_en,
  input  logic [NUM_ROOMS-1:0] override_val,
  output logic [NUM_ROOMS-1:0] lights,
  output logic                 dark
);

  // One spare bit so thresholds at the top of the sensor range still compare.
  localparam int CMP_W = DL_W + 1;
  localparam logic [CMP_W-1:0] ON_LVL  = CMP_W'(ON_THRESH);
  localparam logic [CMP_W-1:0] OFF_LVL = CMP_W'(OFF_THRESH);

  logic [CMP_W-1:0] daylight_ext_s;
  logic             dark_q;

  assign daylight_ext_s = {1'b0, daylight};

  // Hysteresis flag: set strictly below ON level, clear at or above OFF level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dark_q <= 1'b0;
    end else if (daylight_ext_s < ON_LVL) begin
      dark_q <= 1'b1;
    end else if (daylight_ext_s >= OFF_LVL) begin
      dark_q <= 1'b0;
    end else begin
      dark_q <= dark_q;
    end
  end

  assign dark = dark_q;

  for (genvar g = 0; g < NUM_ROOMS; g++) begin : g_room
    room_light_fsm #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_room (
      .clk           (clk),
      .rst           (rst),
      .dark_i        (dark_q),
      .presence_i    (presence[g]),
      .override_en_i (override_en[g]),
      .override_val_i(override_val[g]),
      .light_o       (lights[g])
    );
  end

endmodule

// File: tb/tb_room_light_controller.sv
// Directed self-checking bench for room_light_controller
// (4 rooms, thresholds 100/120, hold of 5 cycles).
module tb_room_light_controller;

  logic       clk;
  logic       rst;
  logic [7:0] daylight;
  logic [3:0] presence;
  logic [3:0] override_en;
  logic [3:0] override_val;
  logic [3:0] lights;
  logic       dark;

  int checks;
  int failures;

  room_light_controller #(
    .NUM_ROOMS  (4),
    .DL_W       (8),
    .ON_THRESH  (100),
    .OFF_THRESH (120),
    .HOLD_CYCLES(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .daylight    (daylight),
    .presence    (presence),
    .override_en (override_en),
    .override_val(override_val),
    .lights      (lights),
    .dark        (dark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; daylight = 8'd100; presence = 4'b0000;
    override_en = 4'b0000; override_val = 4'b0000;
    tick(); tick();
    checks++;
    if (lights !== 4'b0000) begin
      failures++; $display("FAIL reset_lights actual=%b required=%b", lights, 4'b0000);
    end
    checks++;
    if (dark !== 1'b0) begin
      failures++; $display("FAIL reset_dark actual=%b required=%b", dark, 1'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_dark_set();
    daylight = 8'd100; presence = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dark !== 1'b0 || lights !== 4'b0000) begin
        failures++; $display("FAIL at_on_thresh actual=%b/%b required=0/0000", dark, lights);
      end
    end
    daylight = 8'd99;
    tick();
    checks++;
    if (dark !== 1'b1 || lights !== 4'b0000) begin
      failures++; $display("FAIL dark_set_edge1 actual=%b/%b required=1/0000", dark, lights);
    end
    tick();
    checks++;
    if (lights !== 4'b0001) begin
      failures++; $display("FAIL lights_edge2 actual=%b required=0001", lights);
    end
  endtask

  task automatic test_hysteresis();
    daylight = 8'd110;
    tick();
    checks++;
    if (dark !== 1'b1 || lights !== 4'b0001) begin
      failures++; $display("FAIL hyst_hold actual=%b/%b required=1/0001", dark, lights);
    end
    daylight = 8'd120;
    tick();
    checks++;
    if (dark !== 1'b0 || lights !== 4'b0001) begin
      failures++; $display("FAIL hyst_clear actual=%b/%b required=0/0001", dark, lights);
    end
    tick();
    checks++;
    if (dark !== 1'b0 || lights !== 4'b0000) begin
      failures++; $display("FAIL bright_off actual=%b/%b required=0/0000", dark, lights);
    end
  endtask

  task automatic test_hold();
    daylight = 8'd99; presence = 4'b0001;
    tick(); tick();
    checks++;
    if (lights !== 4'b0001) begin
      failures++; $display("FAIL hold_setup actual=%b required=0001", lights);
    end
    presence = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lights !== 4'b0001) begin
        failures++; $display("FAIL hold_lit edge=k+%0d actual=%b required=0001", i, lights);
      end
    end
    tick();
    checks++;
    if (lights !== 4'b0000) begin
      failures++; $display("FAIL hold_expire actual=%b required=0000", lights);
    end
    presence = 4'b0001;
    tick();
    presence = 4'b0000;
    tick(); tick(); tick();
    presence = 4'b0001;
    tick();
    presence = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lights !== 4'b0001) begin
        failures++; $display("FAIL retrigger_lit step=%0d actual=%b required=0001", i, lights);
      end
    end
    tick();
    checks++;
    if (lights !== 4'b0000) begin
      failures++; $display("FAIL retrigger_expire actual=%b required=0000", lights);
    end
  endtask

  task automatic test_override();
    daylight = 8'd200; presence = 4'b0000;
    tick(); tick();
    checks++;
    if (dark !== 1'b0 || lights !== 4'b0000) begin
      failures++; $display("FAIL ovr_setup actual=%b/%b required=0/0000", dark, lights);
    end
    override_en = 4'b0010; override_val = 4'b0010;
    tick();
    checks++;
    if (lights !== 4'b0010) begin
      failures++; $display("FAIL ovr_force_on actual=%b required=0010", lights);
    end
    override_en = 4'b0000; override_val = 4'b0000;
    tick();
    checks++;
    if (lights !== 4'b0000) begin
      failures++; $display("FAIL ovr_release actual=%b required=0000", lights);
    end
    daylight = 8'd99; presence = 4'b0001;
    tick(); tick();
    override_en = 4'b0001; override_val = 4'b0000;
    tick();
    checks++;
    if (lights !== 4'b0000) begin
      failures++; $display("FAIL ovr_force_off actual=%b required=0000", lights);
    end
    override_en = 4'b0000;
    tick();
    checks++;
    if (lights !== 4'b0001) begin
      failures++; $display("FAIL ovr_fsm_kept actual=%b required=0001", lights);
    end
  endtask

  task automatic test_independent();
    presence = 4'b1111;
    tick();
    checks++;
    if (lights !== 4'b1111) begin
      failures++; $display("FAIL indep_all_on actual=%b required=1111", lights);
    end
    presence = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lights !== 4'b1111) begin
        failures++; $display("FAIL indep_hold_hi step=%0d actual=%b required=1111", i, lights);
      end
    end
    tick();
    checks++;
    if (lights !== 4'b0011) begin
      failures++; $display("FAIL indep_hi_off actual=%b required=0011", lights);
    end
    presence = 4'b1100;
    tick();
    checks++;
    if (lights !== 4'b1111) begin
      failures++; $display("FAIL indep_swap actual=%b required=1111", lights);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (lights !== 4'b1111) begin
        failures++; $display("FAIL indep_hold_lo step=%0d actual=%b required=1111", i, lights);
      end
    end
    tick();
    checks++;
    if (lights !== 4'b1100) begin
      failures++; $display("FAIL indep_lo_off actual=%b required=1100", lights);
    end
  endtask

  task automatic test_async_reset();
    presence = 4'b0000;
    tick();
    override_en = 4'b0001; override_val = 4'b0001;
    tick();
    checks++;
    if (lights !== 4'b1101 || dark !== 1'b1) begin
      failures++; $display("FAIL arst_setup actual=%b/%b required=1/1101", dark, lights);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (lights !== 4'b0000 || dark !== 1'b0) begin
      failures++; $display("FAIL arst_immediate actual=%b/%b required=0/0000", dark, lights);
    end
    tick(); tick();
    rst = 1'b0; override_en = 4'b0000; override_val = 4'b0000;
    daylight = 8'd99;
    tick();
    checks++;
    if (dark !== 1'b1 || lights !== 4'b0000) begin
      failures++; $display("FAIL arst_first_edge actual=%b/%b required=1/0000", dark, lights);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_dark_set();
    test_hysteresis();
    test_hold();
    test_override();
    test_independent();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
